// File: rtl/forwarding_hazard_ctrl.sv
// forwarding_hazard_ctrl
// Control side of the EX-stage operand forwarding muxes in a 5-stage MIPS
// pipeline. It tracks the producers in EX and MEM, registers the operand
// select codes for the next EX instruction, and stalls IF/ID for one cycle
// on a load-use hazard. A taken branch/jump (ex_flush) kills ID instead.
//
// Select encoding: 00 register file, 10 EX/MEM ALU result, 01 MEM/WB data.
//
// Optional build macro FWD_STALL_COUNTER_EN adds the stall_count output,
// a saturating count of load-use stall cycles since reset.
//
// The WB slot is not stored. Nothing here reads it, because the register
// file resolves a same-cycle WB write and ID read by writing first.
// mem_read is also dropped once an instruction leaves EX, because only
// the EX slot can raise a load-use hazard.
module forwarding_hazard_ctrl #(
    parameter int                    REG_ADDR_W  = 5,
    parameter logic [REG_ADDR_W-1:0] ZERO_REG    = '0
`ifdef FWD_STALL_COUNTER_EN
    , parameter int                  STALL_CNT_W = 16
`endif
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  id_uses_rt,
    input  logic [REG_ADDR_W-1:0] id_dest,
    input  logic                  id_reg_write,
    input  logic                  id_mem_read,
    input  logic                  ex_flush,
    output logic                  pc_write_en,
    output logic                  ifid_write_en,
    output logic                  idex_bubble,
    output logic [1:0]            fwd_a_sel,
    output logic [1:0]            fwd_b_sel
`ifdef FWD_STALL_COUNTER_EN
    , output logic [STALL_CNT_W-1:0] stall_count
`endif
);

    localparam logic [1:0] SEL_RF  = 2'b00;
    localparam logic [1:0] SEL_EXM = 2'b10;
    localparam logic [1:0] SEL_MWB = 2'b01;

    logic [REG_ADDR_W-1:0] ex_dest;
    logic                  ex_reg_write;
    logic                  ex_mem_read;
    logic [REG_ADDR_W-1:0] mem_dest;
    logic                  mem_reg_write;

    logic ex_hit_rs;
    logic ex_hit_rt;
    logic mem_hit_rs;
    logic mem_hit_rt;
    logic hazard;
    logic stall;
    logic [1:0] next_a_sel;
    logic [1:0] next_b_sel;

    // Producer matches, hazard/stall decode and next select codes
    always_comb begin
        ex_hit_rs  = ex_reg_write  && (ex_dest  != ZERO_REG) && (ex_dest  == id_rs);
        ex_hit_rt  = ex_reg_write  && (ex_dest  != ZERO_REG) && (ex_dest  == id_rt) && id_uses_rt;
        mem_hit_rs = mem_reg_write && (mem_dest != ZERO_REG) && (mem_dest == id_rs);
        mem_hit_rt = mem_reg_write && (mem_dest != ZERO_REG) && (mem_dest == id_rt) && id_uses_rt;

        hazard        = id_valid && ex_mem_read && (ex_hit_rs || ex_hit_rt);
        stall         = hazard && !ex_flush;
        pc_write_en   = !stall;
        ifid_write_en = !stall;
        idex_bubble   = stall || ex_flush || !id_valid;

        // The newest producer (EX) takes priority over MEM
        next_a_sel = SEL_RF;
        next_b_sel = SEL_RF;
        if (!idex_bubble) begin
            if (ex_hit_rs)       next_a_sel = SEL_EXM;
            else if (mem_hit_rs) next_a_sel = SEL_MWB;
            if (ex_hit_rt)       next_b_sel = SEL_EXM;
            else if (mem_hit_rt) next_b_sel = SEL_MWB;
        end
    end

    // Advance the tracking slots and register the selects for the new EX instruction
    always_ff @(posedge clk) begin
        if (reset) begin
            ex_dest       <= '0;
            ex_reg_write  <= 1'b0;
            ex_mem_read   <= 1'b0;
            mem_dest      <= '0;
            mem_reg_write <= 1'b0;
            fwd_a_sel     <= SEL_RF;
            fwd_b_sel     <= SEL_RF;
        end else begin
            mem_dest      <= ex_dest;
            mem_reg_write <= ex_reg_write;
            if (idex_bubble) begin
                ex_dest      <= '0;
                ex_reg_write <= 1'b0;
                ex_mem_read  <= 1'b0;
            end else begin
                ex_dest      <= id_dest;
                ex_reg_write <= id_reg_write;
                ex_mem_read  <= id_mem_read;
            end
            fwd_a_sel <= next_a_sel;
            fwd_b_sel <= next_b_sel;
        end
    end

`ifdef FWD_STALL_COUNTER_EN
    // Count stall cycles and hold at all-ones instead of wrapping
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_count <= '0;
        end else if (stall && (stall_count != {STALL_CNT_W{1'b1}})) begin
            stall_count <= stall_count + 1'b1;
        end
    end
`endif

endmodule
